dog_line_scanner: RTL and testbench
===================================

// Module: dog_line_scanner
// PURPOSE
//  Per-scanline sprite pre-scan stage between game_core_v8 and the VGA pixel mixer. Runs on clk50.
//  - At frame_tick, snapshots all dog state so the whole frame draws from one coherent set.
//  - During each hblank, scans the N dogs serially against the next line's y and builds a line table.
//  - Per pixel, resolves body and hit-bar coverage from that table, so the mixer needs no per-pixel compare of all N dogs.
// PARAMETERS
//  N        8    number of dogs
//  BOX_W    48   dog body width, px
//  BOX_H    32   dog body height, px; full-scale hit-bar height
//  BAR_W    6    hit-bar width, px
// PORTS
//  clk50       in   1      50 MHz system clock
//  rst_n       in   1      asynchronous, active-low reset
//  pix_ce      in   1      pixel-clock enable (every 2nd clk50)
//  frame_tick  in   1      1-clk50 pulse at frame start; qualified by pix_ce
//  line_start  in   1      1-clk50 pulse at hblank start; qualified by pix_ce
//  next_y      in   9      y of the line that follows line_start
//  px          in   10     current pixel x
//  posx        in   10*N   dog x, flat, dog0 in LSBs
//  posy        in   9*N    dog y, flat
//  hits        in   8*N    dog hit count, flat
//  color_idx   in   3*N    dog colour, flat
//  line_ready  out  1      line table valid for the current line
//  body_hit    out  1      px covered by some dog body
//  body_col    out  3      colour of the highest-index covering dog
//  bar_hit     out  1      px covered by some hit bar
//  scan_busy   out  1      scan FSM not in IDLE
// BEHAVIOUR
//  Reset: every output 0. Snapshot, pending and active tables cleared. FSM in IDLE.
//  Snapshot
//  - On frame_tick & pix_ce: posx/posy/hits/color_idx copied to shadow registers.
//  - Shadow registers are the only data the scan reads.
//  FSM: IDLE -> SCAN -> COMMIT -> IDLE
//  - IDLE: on line_start & pix_ce, latch next_y, set i=0, go to SCAN.
//  - SCAN: evaluate dog i, write pending slot i, i++. After i==N-1 go to COMMIT (N clk50 cycles).
//  - COMMIT: copy pending table to active table in one cycle; set line_ready=1; go to IDLE.
//  - Worst case N+2 clk50 cycles, well inside the 320-cycle hblank.
//  Slot i
//  - body_v = (ny >= posy) && (ny < posy+BOX_H), 10-bit unsigned, no wrap.
//  - bar_v  = (ny < posy) && (ny + ht >= posy), evaluated in 10 bits. Equivalent to ny >= posy-ht with the top clamped at 0; never underflows.
//  - ht = (h*BOX_H + ((h*BOX_H)>>8) + 1) >> 8, 14-bit intermediate. This is exactly floor(h*BOX_H/255), so ht(255)=BOX_H and ht(0)=0.
//  - Slot stores: xs = posx, col, body_v, bar_v.
//  Pixel stage, on pix_ce, registered (latency 1 pix_ce)
//  - body_hit = OR over i of body_v[i] && px in [xs, xs+BOX_W).
//  - body_col = col of the highest i that matches; 0 when no slot matches.
//  - bar_hit  = OR over i of bar_v[i] && px in [xs, xs+BAR_W).
//  - Outputs hold between pix_ce pulses.
//  Boundary cases
//  - line_start while not IDLE: abort, restart SCAN at i=0 with the new next_y. Active table untouched; line_ready cleared.
//  - frame_tick and line_start in the same cycle: the snapshot loads first; the scan (starting next clk50) uses the new snapshot.
//  - frame_tick during SCAN: snapshot updates; the in-flight scan completes on mixed data (rejected by team rule: frame_tick is in vblank, so this never occurs on-line).
//  - Dogs overlap: highest index wins the colour.
//  - Bar and body on the same px: both flags set; the mixer gives the bar priority.
//  - rst_n asserted mid-scan: immediate clear, IDLE. line_ready stays 0 until the next COMMIT.
// STRUCTURE
//  - dogbattle_defs.vh: N, BOX_W, BOX_H, BAR_W, SCREEN_W/H, slot field widths and offsets.
//  - Sub-module dog_row_eval: combinational, single dog. Inputs posy, hits, ny; outputs body_v, bar_v.
//    Owns the divide-by-255 height math. One instance, time-shared by SCAN.
//  - Top contains: snapshot registers, FSM, pending/active tables, N parallel x-comparators for the pixel stage.
// TESTING
//  1. Reset, then release with no stimulus -> all outputs 0; scan_busy 0.
//  2. dog0 posx=100, posy=200, col=5, hits=0; frame_tick; line_start with next_y=210, then px=99/100/147/148
//     -> body_hit 0/1/1/0; body_col 5 when hit; bar_hit 0; scan_busy high exactly N+1 clk50.
//  3. dog3 posy=40, hits=255; line_start next_y=8 and 7, px=posx+5, posx+6
//     -> bar_hit 1 at y=8 for px=posx+5, 0 at px=posx+6; bar_hit 0 at y=7. (ht=32.)
//  4. dog1 posy=10, hits=255 (bar would underflow); next_y=0 -> bar_hit 1, no wrap. next_y=479 -> bar_hit 0.
//  5. dog2 and dog6 overlap at the same posx/posy, cols 2 and 6 -> body_col=6.
//  6. line_start re-pulsed 3 clk50 into SCAN with a different next_y -> scan restarts.
//     Committed table reflects the second y; line_ready 0 until that commit.
//     Assert rst_n mid-scan -> outputs 0 within 1 clk50.

Source files
------------

// File: rtl/dog_line_scanner_pkg.sv
// -----------------------------------------------------------------------------
// dog_line_scanner_pkg
// Shared constants and types for the per-scanline dog sprite pre-scan stage.
//   N       number of dogs
//   BOX_W   dog body width in pixels
//   BOX_H   dog body height in pixels, also the full-scale hit-bar height
//   BAR_W   hit-bar width in pixels
//   XW/YW/HW/CW  widths of the per-dog x, y, hit count and colour fields
//   slot_t  one line-table entry produced by the scan for a single dog
// -----------------------------------------------------------------------------
package dog_line_scanner_pkg;

    localparam int N     = 8;
    localparam int BOX_W = 48;
    localparam int BOX_H = 32;
    localparam int BAR_W = 6;

    localparam int XW  = 10;
    localparam int YW  = 9;
    localparam int HW  = 8;
    localparam int CW  = 3;
    localparam int IW  = $clog2(N);
    // Width of the bar-height math; 255*32 + carry terms stays below 2^14.
    localparam int HTW = 14;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } scan_state_e;

    typedef struct packed {
        logic [XW-1:0] xs;
        logic [CW-1:0] col;
        logic          body_v;
        logic          bar_v;
    } slot_t;

endpackage

// File: rtl/dog_row_eval.sv
// -----------------------------------------------------------------------------
// dog_row_eval
// Combinational vertical test of one dog against the line being prepared.
//   posy_i    dog top y
//   hits_i    dog hit count (0..255 maps to a bar of 0..BOX_H pixels)
//   ny_i      y of the line being prepared
//   body_v_o  line crosses the dog body
//   bar_v_o   line crosses the hit bar that sits directly above the body
// -----------------------------------------------------------------------------
module dog_row_eval
    import dog_line_scanner_pkg::*;
(
    input  logic [YW-1:0] posy_i,
    input  logic [HW-1:0] hits_i,
    input  logic [YW-1:0] ny_i,
    output logic          body_v_o,
    output logic          bar_v_o
);

    logic [HTW-1:0] prod;
    logic [HTW-1:0] sum;
    logic [HTW-1:0] ht;
    logic [HTW-1:0] y_w;
    logic [HTW-1:0] ny_w;

    always_comb begin
        // floor(h*BOX_H/255) without a divider: x/255 == (x + x/256 + 1)/256
        // holds exactly for every x this product can take.
        prod = HTW'(hits_i) * HTW'(BOX_H);
        sum  = prod + (prod >> 8) + HTW'(1);
        ht   = sum >> 8;
        y_w  = HTW'(posy_i);
        ny_w = HTW'(ny_i);
        body_v_o = (ny_w >= y_w) && (ny_w < y_w + HTW'(BOX_H));
        // Add ht to the line y rather than subtracting it from posy so a bar
        // near the top of the screen clamps at 0 instead of wrapping.
        bar_v_o  = (ny_w < y_w) && (ny_w + ht >= y_w);
    end

endmodule

// File: rtl/dog_line_scanner.sv
// -----------------------------------------------------------------------------
// dog_line_scanner
// Per-scanline sprite pre-scan between the game core and the VGA pixel mixer.
// Snapshots dog state at frame start, scans the dogs serially during hblank
// into a pending line table, commits it to the active table, and resolves
// body / hit-bar coverage per pixel from the active table.
// Ports:
//   clk50, rst_n (async, active-low), pix_ce (pixel enable)
//   frame_tick   snapshot strobe, qualified by pix_ce
//   line_start   hblank strobe, qualified by pix_ce; next_y is the line to build
//   px           current pixel x
//   posx/posy/hits/color_idx  flat per-dog state, dog0 in the LSBs
//   line_ready   active table holds a committed line
//   body_hit/body_col/bar_hit  registered pixel result (one pix_ce latency)
//   scan_busy    scan FSM not idle
//   dbg_state_o  raw scan FSM state for observation
// Handshake: line_start is a single pix_ce-qualified strobe with no ready;
// a strobe that arrives while a scan is in flight restarts the scan.
// -----------------------------------------------------------------------------
module dog_line_scanner
    import dog_line_scanner_pkg::*;
(
    input  logic            clk50,
    input  logic            rst_n,
    input  logic            pix_ce,
    input  logic            frame_tick,
    input  logic            line_start,
    input  logic [YW-1:0]   next_y,
    input  logic [XW-1:0]   px,
    input  logic [N*XW-1:0] posx,
    input  logic [N*YW-1:0] posy,
    input  logic [N*HW-1:0] hits,
    input  logic [N*CW-1:0] color_idx,
    output logic            line_ready,
    output logic            body_hit,
    output logic [CW-1:0]   body_col,
    output logic            bar_hit,
    output logic            scan_busy,
    output logic [1:0]      dbg_state_o
);

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [XW:0]   BOX_W_X  = (XW + 1)'(BOX_W);
    localparam logic [XW:0]   BAR_W_X  = (XW + 1)'(BAR_W);

    logic [N*XW-1:0] snap_x_q;
    logic [N*YW-1:0] snap_y_q;
    logic [N*HW-1:0] snap_h_q;
    logic [N*CW-1:0] snap_c_q;

    scan_state_e     state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [YW-1:0]   ny_q, ny_d;
    logic            line_ready_q, line_ready_d;
    logic            pend_we;
    logic            commit;
    logic            start;

    slot_t           pend_q [N];
    slot_t           act_q  [N];

    logic [XW-1:0]   cur_x;
    logic [YW-1:0]   cur_y;
    logic [HW-1:0]   cur_h;
    logic [CW-1:0]   cur_c;
    logic            row_body_v;
    logic            row_bar_v;

    logic            body_hit_q, body_hit_d;
    logic [CW-1:0]   body_col_q, body_col_d;
    logic            bar_hit_q, bar_hit_d;
    logic [XW:0]     px_w;

    assign start = line_start & pix_ce;

    // Snapshot: the scan reads only these, so a frame draws from one data set.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            snap_x_q <= '0;
            snap_y_q <= '0;
            snap_h_q <= '0;
            snap_c_q <= '0;
        end else if (frame_tick && pix_ce) begin
            snap_x_q <= posx;
            snap_y_q <= posy;
            snap_h_q <= hits;
            snap_c_q <= color_idx;
        end
    end

    // Dog currently under evaluation; one row evaluator is shared by the scan.
    always_comb begin
        cur_x = snap_x_q[int'(idx_q)*XW +: XW];
        cur_y = snap_y_q[int'(idx_q)*YW +: YW];
        cur_h = snap_h_q[int'(idx_q)*HW +: HW];
        cur_c = snap_c_q[int'(idx_q)*CW +: CW];
    end

    dog_row_eval u_row_eval (
        .posy_i   (cur_y),
        .hits_i   (cur_h),
        .ny_i     (ny_q),
        .body_v_o (row_body_v),
        .bar_v_o  (row_bar_v)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        ny_d         = ny_q;
        line_ready_d = line_ready_q;
        pend_we      = 1'b0;
        commit       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ny_d    = next_y;
                    idx_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                pend_we = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_COMMIT;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            ST_COMMIT: begin
                commit       = 1'b1;
                line_ready_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A new strobe mid-scan restarts from dog 0; the active table is left
        // alone but is no longer vouched for.
        if (start && (state_q != ST_IDLE)) begin
            state_d      = ST_SCAN;
            idx_d        = '0;
            ny_d         = next_y;
            line_ready_d = 1'b0;
            pend_we      = 1'b0;
            commit       = 1'b0;
        end
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            ny_q         <= '0;
            line_ready_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                pend_q[i] <= '0;
                act_q[i]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            ny_q         <= ny_d;
            line_ready_q <= line_ready_d;
            if (pend_we) begin
                pend_q[idx_q] <= '{xs: cur_x, col: cur_c, body_v: row_body_v, bar_v: row_bar_v};
            end
            if (commit) begin
                act_q <= pend_q;
            end
        end
    end

    // Pixel stage: ascending loop so the highest-index covering dog sets the colour.
    always_comb begin
        body_hit_d = 1'b0;
        body_col_d = '0;
        bar_hit_d  = 1'b0;
        px_w       = {1'b0, px};
        for (int i = 0; i < N; i++) begin
            if (act_q[i].body_v && (px_w >= {1'b0, act_q[i].xs}) &&
                (px_w < {1'b0, act_q[i].xs} + BOX_W_X)) begin
                body_hit_d = 1'b1;
                body_col_d = act_q[i].col;
            end
            if (act_q[i].bar_v && (px_w >= {1'b0, act_q[i].xs}) &&
                (px_w < {1'b0, act_q[i].xs} + BAR_W_X)) begin
                bar_hit_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            body_hit_q <= 1'b0;
            body_col_q <= '0;
            bar_hit_q  <= 1'b0;
        end else if (pix_ce) begin
            body_hit_q <= body_hit_d;
            body_col_q <= body_col_d;
            bar_hit_q  <= bar_hit_d;
        end
    end

    assign line_ready  = line_ready_q;
    assign body_hit    = body_hit_q;
    assign body_col    = body_col_q;
    assign bar_hit     = bar_hit_q;
    assign scan_busy   = (state_q != ST_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dog_line_scanner.sv
// -----------------------------------------------------------------------------
// tb_dog_line_scanner
// Self-checking bench for dog_line_scanner. A frame/line-level reference model
// predicts every output each cycle; directed pixel probes pin known values.
// -----------------------------------------------------------------------------
module tb_dog_line_scanner;
    import dog_line_scanner_pkg::*;

    // ---------------- clock / reset ----------------
    logic            clk50 = 1'b0;
    logic            rst_n;
    logic            pix_ce;
    logic            frame_tick;
    logic            line_start;
    logic [YW-1:0]   next_y;
    logic [XW-1:0]   px;
    logic [N*XW-1:0] posx;
    logic [N*YW-1:0] posy;
    logic [N*HW-1:0] hits;
    logic [N*CW-1:0] color_idx;
    logic            line_ready;
    logic            body_hit;
    logic [CW-1:0]   body_col;
    logic            bar_hit;
    logic            scan_busy;
    logic [1:0]      dbg_state;

    int n_vec = 0;
    int n_err = 0;

    initial forever #10 clk50 = ~clk50;

    initial begin
        pix_ce = 1'b0;
        forever begin
            @(negedge clk50);
            pix_ce = ~pix_ce;
        end
    end

    dog_line_scanner dut (
        .clk50       (clk50),
        .rst_n       (rst_n),
        .pix_ce      (pix_ce),
        .frame_tick  (frame_tick),
        .line_start  (line_start),
        .next_y      (next_y),
        .px          (px),
        .posx        (posx),
        .posy        (posy),
        .hits        (hits),
        .color_idx   (color_idx),
        .line_ready  (line_ready),
        .body_hit    (body_hit),
        .body_col    (body_col),
        .bar_hit     (bar_hit),
        .scan_busy   (scan_busy),
        .dbg_state_o (dbg_state)
    );

    // ---------------- reference model ----------------
    // Frame level: snapshot arrays, a countdown for the hblank scan, and a line
    // table rebuilt from the rules at the moment the scan commits.
    int s_x [N], s_y [N], s_h [N], s_c [N];
    int t_x [N], t_c [N];
    bit t_body [N], t_bar [N];
    int m_cnt = 0;
    int m_y = 0;
    bit m_ready = 0, m_body = 0, m_bar = 0;
    int m_col = 0;
    int m_px;
    int m_ht;

    initial forever begin
        @(posedge clk50 or negedge rst_n);
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                s_x[i] = 0; s_y[i] = 0; s_h[i] = 0; s_c[i] = 0;
                t_x[i] = 0; t_c[i] = 0; t_body[i] = 0; t_bar[i] = 0;
            end
            m_cnt = 0; m_y = 0; m_ready = 0; m_body = 0; m_bar = 0; m_col = 0;
        end else begin
            if (pix_ce) begin
                m_px = int'(px);
                m_body = 0; m_bar = 0; m_col = 0;
                for (int i = 0; i < N; i++) begin
                    if (t_body[i] && m_px >= t_x[i] && m_px < t_x[i] + BOX_W) begin
                        m_body = 1;
                        m_col  = t_c[i];
                    end
                    if (t_bar[i] && m_px >= t_x[i] && m_px < t_x[i] + BAR_W) m_bar = 1;
                end
            end
            if (pix_ce && frame_tick) begin
                for (int i = 0; i < N; i++) begin
                    s_x[i] = int'(posx[i*XW +: XW]);
                    s_y[i] = int'(posy[i*YW +: YW]);
                    s_h[i] = int'(hits[i*HW +: HW]);
                    s_c[i] = int'(color_idx[i*CW +: CW]);
                end
            end
            if (pix_ce && line_start) begin
                if (m_cnt != 0) m_ready = 0;
                m_cnt = N + 1;
                m_y   = int'(next_y);
            end else if (m_cnt != 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    for (int i = 0; i < N; i++) begin
                        m_ht      = (s_h[i] * BOX_H) / 255;
                        t_body[i] = (m_y >= s_y[i]) && (m_y < s_y[i] + BOX_H);
                        t_bar[i]  = (m_y < s_y[i]) && (m_y + m_ht >= s_y[i]);
                        t_x[i]    = s_x[i];
                        t_c[i]    = s_c[i];
                    end
                    m_ready = 1;
                end
            end
        end
    end

    // ---------------- scoreboard: every cycle ----------------
    initial forever begin
        @(negedge clk50);
        n_vec++;
        if (body_hit !== m_body || bar_hit !== m_bar || body_col !== CW'(m_col) ||
            line_ready !== m_ready || scan_busy !== (m_cnt != 0)) begin
            n_err++;
            $display("FAIL model t=%0t: dut body/col/bar/ready/busy=%b/%0d/%b/%b/%b required %b/%0d/%b/%b/%b",
                     $time, body_hit, body_col, bar_hit, line_ready, scan_busy,
                     m_body, m_col, m_bar, m_ready, (m_cnt != 0));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic wait_slot();
        for (int k = 0; k < 4 && pix_ce !== 1'b1; k++) begin
            @(negedge clk50); #1;
        end
    endtask

    task automatic set_dog(input int i, input int x, input int y, input int h, input int c);
        posx[i*XW +: XW]      = XW'(x);
        posy[i*YW +: YW]      = YW'(y);
        hits[i*HW +: HW]      = HW'(h);
        color_idx[i*CW +: CW] = CW'(c);
    endtask

    task automatic load_frame();
        wait_slot();
        frame_tick = 1'b1;
        @(negedge clk50); #1;
        frame_tick = 1'b0;
    endtask

    task automatic start_line(input int y, input bit ft);
        wait_slot();
        next_y     = YW'(y);
        line_start = 1'b1;
        frame_tick = ft;
        @(negedge clk50); #1;
        line_start = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        for (int k = 0; k < 40 && scan_busy; k++) begin
            cyc++;
            @(negedge clk50); #1;
        end
    endtask

    task automatic px_check(input string nm, input int x, input int eb, input int ec, input int ebar);
        wait_slot();
        px = XW'(x);
        @(negedge clk50); #1;
        check({nm, "_body"}, int'(body_hit), eb);
        check({nm, "_col"},  int'(body_col), ec);
        check({nm, "_bar"},  int'(bar_hit),  ebar);
    endtask

    initial begin
        #5_000_000;
        n_err++;
        $display("FAIL timeout: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // ---------------- stimulus ----------------
    int busy;
    bit ft;

    initial begin
        rst_n = 1'b1; frame_tick = 1'b0; line_start = 1'b0; next_y = '0; px = '0;
        posx = '0; posy = '0; hits = '0; color_idx = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk50);
        #1 rst_n = 1'b1;

        // Reset state with no stimulus.
        repeat (3) @(negedge clk50);
        #1;
        check("rst_body", int'(body_hit), 0);
        check("rst_col", int'(body_col), 0);
        check("rst_bar", int'(bar_hit), 0);
        check("rst_ready", int'(line_ready), 0);
        check("rst_busy", int'(scan_busy), 0);

        // Directed frame: dogs parked off-screen except the ones under test.
        for (int i = 0; i < N; i++) set_dog(i, 900, 500, 0, 0);
        set_dog(0, 100, 200, 0, 5);
        set_dog(1, 400, 10, 255, 1);
        set_dog(2, 200, 100, 0, 2);
        set_dog(3, 300, 40, 255, 3);
        set_dog(6, 200, 100, 0, 6);
        load_frame();

        // Body edges and scan length.
        start_line(210, 0);
        wait_idle(busy);
        check("scan_len", busy, N + 1);
        check("t2_ready", int'(line_ready), 1);
        px_check("t2_px99", 99, 0, 0, 0);
        px_check("t2_px100", 100, 1, 5, 0);
        px_check("t2_px147", 147, 1, 5, 0);
        px_check("t2_px148", 148, 0, 0, 0);

        // Full-scale bar: 32 px above posy=40, 6 px wide.
        start_line(8, 0);
        wait_idle(busy);
        px_check("t3_y8_px305", 305, 0, 0, 1);
        px_check("t3_y8_px306", 306, 0, 0, 0);
        start_line(7, 0);
        wait_idle(busy);
        px_check("t3_y7_px305", 305, 0, 0, 0);

        // Bar that would reach above the screen top clamps instead of wrapping.
        start_line(0, 0);
        wait_idle(busy);
        px_check("t4_y0", 400, 0, 0, 1);
        start_line(479, 0);
        wait_idle(busy);
        px_check("t4_y479", 400, 0, 0, 0);

        // Overlap: highest index wins the colour.
        start_line(110, 0);
        wait_idle(busy);
        px_check("t5_overlap", 210, 1, 6, 0);

        // Abort and restart with a different line.
        start_line(210, 0);
        repeat (3) @(negedge clk50);
        #1;
        start_line(110, 0);
        check("t6_ready_abort", int'(line_ready), 0);
        wait_idle(busy);
        check("t6_scan_len", busy, N + 1);
        check("t6_ready", int'(line_ready), 1);
        px_check("t6_px100", 100, 0, 0, 0);
        px_check("t6_px210", 210, 1, 6, 0);

        // Reset in the middle of a scan.
        start_line(210, 0);
        @(negedge clk50);
        #1 rst_n = 1'b0;
        #1;
        check("mrst_body", int'(body_hit), 0);
        check("mrst_col", int'(body_col), 0);
        check("mrst_busy", int'(scan_busy), 0);
        check("mrst_ready", int'(line_ready), 0);
        @(negedge clk50);
        #1 rst_n = 1'b1;
        repeat (6) @(negedge clk50);
        #1;
        check("mrst_ready_hold", int'(line_ready), 0);

        // Randomised frames, lines, aborts and same-cycle frame/line strobes.
        for (int f = 0; f < 25; f++) begin
            for (int i = 0; i < N; i++) begin
                set_dog(i, $urandom_range(0, 620), $urandom_range(0, 300),
                        ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255),
                        $urandom_range(0, 7));
            end
            for (int l = 0; l < 4; l++) begin
                ft = (l == 0) && (f % 3 == 0);
                if (l == 0 && !ft) load_frame();
                if ($urandom_range(0, 3) == 0) begin
                    start_line($urandom_range(0, 330), ft);
                    ft = 1'b0;
                    repeat ($urandom_range(1, 6)) @(negedge clk50);
                    #1;
                end
                start_line($urandom_range(0, 330), ft);
                wait_idle(busy);
                check("rnd_scan_len", busy, N + 1);
                repeat (30) begin
                    @(negedge clk50); #1;
                    px = XW'($urandom_range(0, 679));
                end
            end
        end

        repeat (4) @(negedge clk50);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
